ifid_pipe_ctrl: RTL and testbench

Controller for the IF/ID pipeline register in front of the decode-stage instruction mux. It captures fetched instructions and PCs, and sequences pipeline flushes after control redirects. It detects load-use hazards and stalls fetch, and it drives the NOP-select flush line into the decode mux. It also keeps a saturating bubble counter for performance monitoring.

---
 rtl/ifid_pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_ifid_pipe_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ifid_pipe_ctrl.sv
// IF/ID pipeline register controller: captures fetched instruction/PC, sequences
// post-redirect flushes, detects load-use hazards and counts bubble cycles.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal fetch; IF/ID loads whenever imem presents a word
// ST_FLUSH | decode forced to NOP; flush_cnt_q counts remaining cycles
module ifid_pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] PC_RESET     = 32'h0000_0000,
    parameter int unsigned CNT_W        = 16,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic             imem_valid_in,
    input  logic             redirect_in,
    input  logic             stall_ext_in,
    input  logic             ex_mem_read_in,
    input  logic [4:0]       ex_rd_addr_in,
    input  logic             cnt_clr_in,
    output logic             pc_we_out,
    output logic [31:0]      instr_out,
    output logic [31:0]      pc_out,
    output logic             valid_out,
    output logic             flush_out,
    output logic             stall_out,
    output logic [CNT_W-1:0] bubble_cnt_out
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              pc_we_raw;
    logic              stall_raw;

    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;

    assign opc = instr_q[6:0];
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];

    // LUI/AUIPC/JAL carry immediate bits in the rs1 field
    assign rs1_used = !(opc inside {7'b0110111, 7'b0010111, 7'b1101111});
    assign rs2_used = opc inside {7'b0110011, 7'b0100011, 7'b1100011};

    assign load_use = (state_q == ST_RUN) && valid_q && ex_mem_read_in &&
                      (ex_rd_addr_in != 5'd0) &&
                      ((rs1_used && (rs1 == ex_rd_addr_in)) ||
                       (rs2_used && (rs2 == ex_rd_addr_in)));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        pc_we_raw   = 1'b0;
        stall_raw   = 1'b0;

        if (stall_ext_in) begin
            // full freeze; a pending redirect is re-presented by EX afterwards
        end else if (redirect_in) begin
            pc_we_raw   = 1'b1;
            valid_d     = 1'b0;
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
        end else if (load_use) begin
            stall_raw = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            pc_we_raw = imem_valid_in;
            if (flush_cnt_q == 4'd0) begin
                state_d = ST_RUN;
            end else begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
        end else if (!imem_valid_in) begin
            valid_d = 1'b0;
        end else begin
            pc_we_raw = 1'b1;
            instr_d   = instr_in;
            pc_d      = pc_in;
            valid_d   = 1'b1;
        end
    end

    // pc_we is purely combinational from inputs, so gate it while in reset
    assign pc_we_out = pc_we_raw && rst_n_in;
    assign stall_out = stall_raw;
    assign flush_out = (state_q == ST_FLUSH) || !valid_q;
    assign valid_out = valid_q && (state_q == ST_RUN);
    assign instr_out = flush_out ? NOP_INSTR : instr_q;
    assign pc_out    = pc_q;

    always_comb begin
        bubble_d = bubble_q;
        if (cnt_clr_in) begin
            bubble_d = '0;
        end else if ((flush_out || stall_out) && !stall_ext_in && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    assign bubble_cnt_out = bubble_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
            instr_q     <= NOP_INSTR;
            pc_q        <= PC_RESET;
            valid_q     <= 1'b0;
            bubble_q    <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            bubble_q    <= bubble_d;
        end
    end

endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Directed-vector bench for ifid_pipe_ctrl: a driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_ifid_pipe_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] ADD  = 32'h0072_8333; // add x6,x5,x7
    localparam logic [31:0] LUI  = 32'h0002_82B7; // lui x5,0x28 (rs1 field = 5)
    localparam logic [31:0] SW   = 32'h0051_2023; // sw x5,0(x2)
    localparam logic [31:0] PCR  = 32'h0000_0100;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        imem_valid_in;
    logic        redirect_in;
    logic        stall_ext_in;
    logic        ex_mem_read_in;
    logic [4:0]  ex_rd_addr_in;
    logic        cnt_clr_in;
    logic        pc_we_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        flush_out;
    logic        stall_out;
    logic [3:0]  bubble_cnt_out;

    ifid_pipe_ctrl #(
        .FLUSH_CYCLES(2),
        .PC_RESET    (PCR),
        .CNT_W       (4),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .instr_in      (instr_in),
        .pc_in         (pc_in),
        .imem_valid_in (imem_valid_in),
        .redirect_in   (redirect_in),
        .stall_ext_in  (stall_ext_in),
        .ex_mem_read_in(ex_mem_read_in),
        .ex_rd_addr_in (ex_rd_addr_in),
        .cnt_clr_in    (cnt_clr_in),
        .pc_we_out     (pc_we_out),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .flush_out     (flush_out),
        .stall_out     (stall_out),
        .bubble_cnt_out(bubble_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          idx;
        logic        pc_we;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        stall;
        logic [3:0]  bub;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_idx  = 0;
    int   bub_acc  = 0;

    task automatic chk1(input string name, input int idx, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL v%0d %s actual=%0b required=%0b", idx, name, act, req);
        end
    endtask

    task automatic chk32(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL v%0d %s actual=%08h required=%08h", idx, name, act, req);
        end
    endtask

    // apply one cycle of inputs and queue the outputs expected before the next edge
    task automatic step(input logic r, input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rd, input logic sx, input logic mr, input logic [4:0] exrd,
                        input logic clr, input logic e_we, input logic [31:0] e_ins,
                        input logic [31:0] e_pc, input logic e_v, input logic e_f, input logic e_s);
        exp_t e;
        @(posedge clk_in);
        #1;
        rst_n_in       = r;
        imem_valid_in  = iv;
        instr_in       = ins;
        pc_in          = pc;
        redirect_in    = rd;
        stall_ext_in   = sx;
        ex_mem_read_in = mr;
        ex_rd_addr_in  = exrd;
        cnt_clr_in     = clr;
        e.idx   = vec_idx;
        e.pc_we = e_we;
        e.instr = e_ins;
        e.pc    = e_pc;
        e.valid = e_v;
        e.flush = e_f;
        e.stall = e_s;
        e.bub   = r ? 4'(bub_acc) : 4'd0;
        exp_q.push_back(e);
        if (!r || clr) bub_acc = 0;
        else if ((e_f || e_s) && !sx && bub_acc < 15) bub_acc++;
        vec_idx++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk1 ("pc_we",  e.idx, pc_we_out, e.pc_we);
                chk32("instr",  e.idx, instr_out, e.instr);
                chk32("pc",     e.idx, pc_out,    e.pc);
                chk1 ("valid",  e.idx, valid_out, e.valid);
                chk1 ("flush",  e.idx, flush_out, e.flush);
                chk1 ("stall",  e.idx, stall_out, e.stall);
                chk32("bubble", e.idx, {28'd0, bubble_cnt_out}, {28'd0, e.bub});
            end
        end
    end

    initial begin : driver
        rst_n_in = 1'b0; imem_valid_in = 1'b0; instr_in = '0; pc_in = '0;
        redirect_in = 1'b0; stall_ext_in = 1'b0; ex_mem_read_in = 1'b0;
        ex_rd_addr_in = '0; cnt_clr_in = 1'b0;

        //   r  iv instr pc      rd sx mr rd  clr | we instr pc    v  f  s
        step(0, 1, ADDI, 32'h00, 0, 0, 0, 0,  0,   0, NOP,  PCR,  0, 1, 0);
        step(1, 1, ADDI, 32'h00, 0, 0, 0, 0,  0,   1, NOP,  PCR,  0, 1, 0);
        step(1, 1, ADDI, 32'h04, 0, 0, 0, 0,  0,   1, ADDI, 32'h00, 1, 0, 0);
        step(1, 1, ADDI, 32'h08, 0, 0, 0, 0,  0,   1, ADDI, 32'h04, 1, 0, 0);
        // redirect; FLUSH for two cycles plus one empty RUN cycle
        step(1, 1, ADDI, 32'h0c, 1, 0, 0, 0,  0,   1, ADDI, 32'h08, 1, 0, 0);
        step(1, 1, ADDI, 32'h40, 0, 0, 0, 0,  0,   1, NOP,  32'h08, 0, 1, 0);
        step(1, 1, ADDI, 32'h44, 0, 0, 0, 0,  0,   1, NOP,  32'h08, 0, 1, 0);
        step(1, 1, ADDI, 32'h48, 0, 0, 0, 0,  0,   1, NOP,  32'h08, 0, 1, 0);
        step(1, 1, ADD,  32'h4c, 0, 0, 0, 0,  0,   1, ADDI, 32'h48, 1, 0, 0);
        // load-use on rs1, then released
        step(1, 1, ADDI, 32'h50, 0, 0, 1, 5,  0,   0, ADD,  32'h4c, 1, 0, 1);
        step(1, 1, ADDI, 32'h50, 0, 0, 0, 5,  0,   1, ADD,  32'h4c, 1, 0, 0);
        // ex_rd=0 never stalls; LUI ignores its rs1 field; SW stalls on rs2
        step(1, 1, LUI,  32'h54, 0, 0, 1, 0,  0,   1, ADDI, 32'h50, 1, 0, 0);
        step(1, 1, SW,   32'h58, 0, 0, 1, 5,  0,   1, LUI,  32'h54, 1, 0, 0);
        step(1, 1, ADDI, 32'h5c, 0, 0, 1, 5,  0,   0, SW,   32'h58, 1, 0, 1);
        step(1, 1, ADDI, 32'h5c, 0, 0, 1, 7,  0,   1, SW,   32'h58, 1, 0, 0);
        // freeze with redirect during FLUSH
        step(1, 1, ADDI, 32'h60, 1, 0, 0, 0,  0,   1, ADDI, 32'h5c, 1, 0, 0);
        step(1, 1, ADDI, 32'h60, 1, 1, 0, 0,  0,   0, NOP,  32'h5c, 0, 1, 0);
        step(1, 1, ADDI, 32'h60, 1, 1, 0, 0,  0,   0, NOP,  32'h5c, 0, 1, 0);
        step(1, 1, ADDI, 32'h60, 1, 1, 0, 0,  0,   0, NOP,  32'h5c, 0, 1, 0);
        step(1, 1, ADDI, 32'h64, 0, 0, 0, 0,  0,   1, NOP,  32'h5c, 0, 1, 0);
        step(1, 0, ADDI, 32'h00, 0, 0, 0, 0,  0,   0, NOP,  32'h5c, 0, 1, 0);
        step(1, 1, ADDI, 32'h80, 0, 0, 0, 0,  0,   1, NOP,  32'h5c, 0, 1, 0);
        step(1, 0, ADDI, 32'h00, 0, 0, 0, 0,  0,   0, ADDI, 32'h80, 1, 0, 0);
        step(1, 0, ADDI, 32'h00, 0, 0, 0, 0,  0,   0, NOP,  32'h80, 0, 1, 0);
        // redirect inside FLUSH restarts the flush length
        step(1, 1, ADDI, 32'h84, 1, 0, 0, 0,  0,   1, NOP,  32'h80, 0, 1, 0);
        step(1, 1, ADDI, 32'h84, 0, 0, 0, 0,  0,   1, NOP,  32'h80, 0, 1, 0);
        step(1, 1, ADDI, 32'h84, 1, 0, 0, 0,  0,   1, NOP,  32'h80, 0, 1, 0);
        step(1, 1, ADDI, 32'h84, 0, 0, 0, 0,  0,   1, NOP,  32'h80, 0, 1, 0);
        step(1, 1, ADDI, 32'h84, 0, 0, 0, 0,  0,   1, NOP,  32'h80, 0, 1, 0);
        // bubble counter saturated at 15, then clear beats a concurrent bubble
        step(1, 0, ADDI, 32'h00, 0, 0, 0, 0,  0,   0, NOP,  32'h80, 0, 1, 0);
        step(1, 1, ADDI, 32'h90, 0, 0, 0, 0,  1,   1, NOP,  32'h80, 0, 1, 0);
        step(1, 1, ADDI, 32'h94, 0, 0, 0, 0,  0,   1, ADDI, 32'h90, 1, 0, 0);
        // reset asserted mid-FLUSH
        step(1, 1, ADDI, 32'h98, 1, 0, 0, 0,  0,   1, ADDI, 32'h94, 1, 0, 0);
        step(1, 1, ADDI, 32'h98, 0, 0, 0, 0,  0,   1, NOP,  32'h94, 0, 1, 0);
        step(0, 1, ADDI, 32'h98, 0, 0, 0, 0,  0,   0, NOP,  PCR,    0, 1, 0);
        step(1, 1, ADDI, 32'ha0, 0, 0, 0, 0,  0,   1, NOP,  PCR,    0, 1, 0);
        step(1, 1, ADDI, 32'ha4, 0, 0, 0, 0,  0,   1, ADDI, 32'ha0, 1, 0, 0);
        step(1, 0, ADDI, 32'h00, 0, 0, 0, 0,  0,   0, ADDI, 32'ha4, 1, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_in);
        @(posedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
